// File: rtl/decode_stage.sv
// decode_stage: MIPS-style ID stage with register file and ID/EX latch; DECODE_BYPASS_EN enables write-to-read bypass.
module decode_stage #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_instr,
  input  logic [31:0] if_id_npc,
  input  logic        id_flush,
  input  logic        mem_wb_reg_write,
  input  logic [4:0]  mem_wb_write_reg,
  input  logic [31:0] mem_wb_write_data,
  output logic [1:0]  id_ex_wb,
  output logic [2:0]  id_ex_m,
  output logic [3:0]  id_ex_ex,
  output logic [31:0] id_ex_npc,
  output logic [31:0] id_ex_rd1,
  output logic [31:0] id_ex_rd2,
  output logic [31:0] id_ex_sign_ext,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd
);
  logic [31:0] regs [NUM_REGS];
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rd1, rd2, sext;
  logic [1:0]  wb;
  logic [2:0]  m;
  logic [3:0]  ex;
  logic        is_r, is_lw, is_sw, is_beq;
  assign op     = if_id_instr[31:26];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rd     = if_id_instr[15:11];
  assign sext   = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
  assign is_r   = op == 6'b000000;
  assign is_lw  = op == 6'b100011;
  assign is_sw  = op == 6'b101011;
  assign is_beq = op == 6'b000100;
  always_comb begin
    wb = is_r ? 2'b10 : is_lw ? 2'b11 : 2'b00;
    m  = is_lw ? 3'b010 : is_sw ? 3'b001 : is_beq ? 3'b100 : 3'b000;
    ex = is_r ? 4'b1100 : (is_lw || is_sw) ? 4'b0001 : is_beq ? 4'b0010 : 4'b0000;
  end
`ifdef DECODE_BYPASS_EN
  assign rd1 = rs == 5'd0 ? 32'd0 : (mem_wb_reg_write && mem_wb_write_reg == rs) ? mem_wb_write_data : regs[rs];
  assign rd2 = rt == 5'd0 ? 32'd0 : (mem_wb_reg_write && mem_wb_write_reg == rt) ? mem_wb_write_data : regs[rt];
`else
  assign rd1 = rs == 5'd0 ? 32'd0 : regs[rs];
  assign rd2 = rt == 5'd0 ? 32'd0 : regs[rt];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else if (mem_wb_reg_write && mem_wb_write_reg != 5'd0) begin
      regs[mem_wb_write_reg] <= mem_wb_write_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_wb       <= '0;
      id_ex_m        <= '0;
      id_ex_ex       <= '0;
      id_ex_npc      <= '0;
      id_ex_rd1      <= '0;
      id_ex_rd2      <= '0;
      id_ex_sign_ext <= '0;
      id_ex_rt       <= '0;
      id_ex_rd       <= '0;
    end else begin
      id_ex_wb       <= id_flush ? 2'b00 : wb;
      id_ex_m        <= id_flush ? 3'b000 : m;
      id_ex_ex       <= id_flush ? 4'b0000 : ex;
      id_ex_npc      <= if_id_npc;
      id_ex_rd1      <= rd1;
      id_ex_rd2      <= rd2;
      id_ex_sign_ext <= sext;
      id_ex_rt       <= rt;
      id_ex_rd       <= rd;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage against a behavioural model; honours DECODE_BYPASS_EN.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst, id_flush, mem_wb_reg_write;
  logic [31:0] if_id_instr, if_id_npc, mem_wb_write_data;
  logic [4:0]  mem_wb_write_reg;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc, id_ex_rd1, id_ex_rd2, id_ex_sign_ext;
  logic [4:0]  id_ex_rt, id_ex_rd;
  logic [31:0] model_regs [32];
  int checks = 0, failures = 0;
`ifdef DECODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  decode_stage dut (
    .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
    .id_flush(id_flush), .mem_wb_reg_write(mem_wb_reg_write),
    .mem_wb_write_reg(mem_wb_write_reg), .mem_wb_write_data(mem_wb_write_data),
    .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex), .id_ex_npc(id_ex_npc),
    .id_ex_rd1(id_ex_rd1), .id_ex_rd2(id_ex_rd2), .id_ex_sign_ext(id_ex_sign_ext),
    .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctl(input logic [5:0] op);
    case (op)
      6'b000000: return 9'b10_000_1100;
      6'b100011: return 9'b11_010_0001;
      6'b101011: return 9'b00_001_0001;
      6'b000100: return 9'b00_100_0010;
      default:   return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a, input logic we, input logic [4:0] wr, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (BYPASS && we && wr == a) return wd;
    return model_regs[a];
  endfunction

  // One cycle: drive after negedge, predict, sample 1ns after the rising edge, then commit the model write.
  task automatic cyc(input logic r, input logic fl, input logic [31:0] ins, input logic [31:0] npc,
                     input logic we, input logic [4:0] wr, input logic [31:0] wd);
    logic [8:0]  c;
    logic [31:0] e_rd1, e_rd2, e_sx, e_npc;
    logic [4:0]  e_rt, e_rd;
    rst = r; id_flush = fl; if_id_instr = ins; if_id_npc = npc;
    mem_wb_reg_write = we; mem_wb_write_reg = wr; mem_wb_write_data = wd;
    c     = fl ? 9'b0 : ctl(ins[31:26]);
    e_rd1 = rd_model(ins[25:21], we, wr, wd);
    e_rd2 = rd_model(ins[20:16], we, wr, wd);
    e_sx  = {{16{ins[15]}}, ins[15:0]};
    e_npc = npc;
    e_rt  = ins[20:16];
    e_rd  = ins[15:11];
    if (r) begin
      c = 0; e_rd1 = 0; e_rd2 = 0; e_sx = 0; e_npc = 0; e_rt = 0; e_rd = 0;
    end
    @(posedge clk);
    #1;
    check("wb", {30'd0, id_ex_wb}, {30'd0, c[8:7]});
    check("m", {29'd0, id_ex_m}, {29'd0, c[6:4]});
    check("ex", {28'd0, id_ex_ex}, {28'd0, c[3:0]});
    check("npc", id_ex_npc, e_npc);
    check("rd1", id_ex_rd1, e_rd1);
    check("rd2", id_ex_rd2, e_rd2);
    check("sext", id_ex_sign_ext, e_sx);
    check("rt", {27'd0, id_ex_rt}, {27'd0, e_rt});
    check("rd", {27'd0, id_ex_rd}, {27'd0, e_rd});
    if (r) for (int i = 0; i < 32; i++) model_regs[i] = 0;
    else if (we && wr != 0) model_regs[wr] = wd;
    @(negedge clk);
  endtask

  initial begin
    logic [5:0]  ops [5];
    logic [31:0] ins;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000};
    for (int i = 0; i < 32; i++) model_regs[i] = 32'hxxxxxxxx;
    @(negedge clk);
    cyc(1, 0, 32'h0, 32'h0, 0, 0, 0);
    cyc(1, 1, 32'hFFFFFFFF, 32'h1234, 1, 5'd3, 32'h33);
    for (int i = 1; i < 32; i++) cyc(0, 0, {6'd0, i[4:0], i[4:0], 16'd0}, 32'h0, 0, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 1, 5'd1, 32'h11);
    cyc(0, 0, 32'h0, 32'h0, 1, 5'd2, 32'h22);
    cyc(0, 0, 32'h00221820, 32'h4, 0, 0, 0);
    check("q_add_rd1", id_ex_rd1, 32'h11);
    check("q_add_rd2", id_ex_rd2, 32'h22);
    check("q_add_rd", {27'd0, id_ex_rd}, 32'd3);
    check("q_add_ex", {28'd0, id_ex_ex}, 32'hC);
    cyc(0, 0, 32'h8C22FFFC, 32'h8, 0, 0, 0);
    check("q_lw_sext", id_ex_sign_ext, 32'hFFFFFFFC);
    check("q_lw_m", {29'd0, id_ex_m}, 32'h2);
    cyc(0, 0, 32'h0, 32'hC, 1, 5'd0, 32'h0000DEAD);
    cyc(0, 0, 32'h00001820, 32'h10, 0, 0, 0);
    check("q_r0_rd1", id_ex_rd1, 32'h0);
    cyc(1, 0, 32'h0, 32'h0, 0, 0, 0);
    cyc(0, 0, 32'h00A00020, 32'h4, 1, 5'd5, 32'h55);
    check("q_byp_rd1", id_ex_rd1, BYPASS ? 32'h55 : 32'h0);
    cyc(0, 0, 32'h00A00020, 32'h8, 0, 0, 0);
    check("q_byp_next", id_ex_rd1, 32'h55);
    cyc(0, 1, 32'hAC220008, 32'hC, 0, 0, 0);
    check("q_sw_flush_ctl", {23'd0, id_ex_wb, id_ex_m, id_ex_ex}, 32'h0);
    cyc(0, 0, 32'hAC220008, 32'h10, 0, 0, 0);
    check("q_sw_ctl", {23'd0, id_ex_wb, id_ex_m, id_ex_ex}, 32'h011);
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) ins[25:21] = 5'd0;
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, ins, $urandom,
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter NUM_REGS, default 32, number of architectural registers; SHALL only be 32, and the register address is fixed at 5 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 if_id_instr  input  32  instruction from the fetch-stage IF/ID latch.
REQ-005 if_id_npc  input  32  PC+4 from the fetch-stage IF/ID latch.
REQ-006 id_flush  input  1  high: the captured control is a bubble.
REQ-007 mem_wb_reg_write  input  1  writeback write enable.
REQ-008 mem_wb_write_reg  input  5  writeback destination register.
REQ-009 mem_wb_write_data  input  32  writeback data.
REQ-010 id_ex_wb  output  2  registered {regwrite, memtoreg}.
REQ-011 id_ex_m  output  3  registered {branch, memread, memwrite}.
REQ-012 id_ex_ex  output  4  registered {regdst, aluop[1:0], alusrc}.
REQ-013 id_ex_npc, id_ex_rd1, id_ex_rd2, id_ex_sign_ext  output  32 each  registered npc, rs data, rt data and sign-extended immediate.
REQ-014 id_ex_rt, id_ex_rd  output  5 each  registered instr[20:16] and instr[15:11].

Function
REQ-015 Field decode SHALL be as follows: opcode = instr[31:26]; rs = [25:21]; rt = [20:16]; rd = [15:11]; sign_ext = {16{instr[15]}, instr[15:0]}.
REQ-016 Control decode SHALL be combinational, with {wb, m, ex} set per opcode as follows:
  - 000000 (R-type): 10 / 000 / 1100.
  - 100011 (lw): 11 / 010 / 0001.
  - 101011 (sw): 00 / 001 / 0001.
  - 000100 (beq): 00 / 100 / 0010.
  - any other opcode: all zero (NOP).
REQ-017 The register file SHALL hold NUM_REGS x 32-bit registers, with 2 combinational read ports (rs, rt) and 1 write port.
REQ-018 The write port SHALL update register mem_wb_write_reg with mem_wb_write_data at the rising edge when mem_wb_reg_write=1 and rst=0.
REQ-019 Register 0 SHALL read as 0 at all times; writes to register 0 SHALL be discarded.
REQ-020 The ID/EX latch SHALL capture all decoded fields, read data and if_id_npc at every rising edge when rst=0; there SHALL be no stall.
REQ-021 Latency SHALL be one cycle: inputs presented in cycle N SHALL appear on the id_ex_* outputs after edge N+1.
REQ-022 With id_flush=1 at the edge, id_ex_wb, id_ex_m and id_ex_ex SHALL load 0; the data fields SHALL load normally.
REQ-023 Simultaneous rst and id_flush: rst SHALL take priority.
REQ-024 Simultaneous writeback and read of the same nonzero register: the result SHALL be as defined under Configuration.
REQ-025 An all-zero instruction (bubble from the fetch latch) SHALL decode as R-type with rd=0; its write is harmless because register 0 discards writes.

Reset
REQ-026 With rst=1 at an edge, all id_ex_* outputs SHALL become 0 and all registers SHALL be cleared to 0.
REQ-027 A writeback presented in a reset cycle SHALL be discarded.
REQ-028 Reset asserted mid-stream SHALL drop the instruction held in ID/EX; there SHALL be no partial state.

Configuration
REQ-029 The macro DECODE_BYPASS_EN SHALL select read-during-write behaviour.
REQ-030 With DECODE_BYPASS_EN defined: when mem_wb_reg_write=1, mem_wb_write_reg is nonzero and equals rs (or rt), the read port SHALL return mem_wb_write_data in the same cycle, so ID/EX captures the new value.
REQ-031 With DECODE_BYPASS_EN undefined: the read port SHALL return the pre-write value; the new value SHALL be visible from the next cycle.

Verification
REQ-032 Reset: rst=1 for 2 cycles -> all id_ex_* = 0; reads of r1..r31 return 0.
REQ-033 Writeback r1=0x00000011, r2=0x00000022, then instr 0x00221820 with npc 0x4 -> next edge gives:
  - rd1=0x11, rd2=0x22, rt=2, rd=3;
  - wb=10, m=000, ex=1100, npc=0x4.
REQ-034 instr 0x8C22FFFC (lw) -> sign_ext=0xFFFFFFFC, wb=11, m=010, ex=0001.
REQ-035 Writeback r0=0x0000DEAD, then instr 0x00001820 -> rd1=0, rd2=0.
REQ-036 After reset, in the same cycle write r5=0x55 and present instr 0x00A00020 -> rd1=0x55 with DECODE_BYPASS_EN, rd1=0 without it; the following cycle gives 0x55 in both builds.
REQ-037 instr 0xAC220008 (sw) with id_flush=1 -> wb=000... all control zero, sign_ext=0x8, rt=2; the same input with id_flush=0 -> m=001, ex=0001.
